// File: rtl/delay_counter_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// delay_counter_arbiter_pkg : shared state encoding and default sizes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package delay_counter_arbiter_pkg;
  localparam int STATE_W   = 2;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/delay_counter_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching upward from last+1
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import delay_counter_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] win_onehot,
  output logic [IDXW-1:0] win_idx,
  output logic            any
);

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    // k runs to NREQ so the previous winner is considered last
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && req[(int'(last) + k) % NREQ]) begin
        any                                = 1'b1;
        win_idx                            = IDXW'((int'(last) + k) % NREQ);
        win_onehot[(int'(last) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/delay_counter_arbiter.sv
// ---------------------------------------------------------------------------
// delay_counter_arbiter : one shared delay counter granted round-robin
// Optional macro DELAY_COUNTER_ARBITER_ABORT_EN: owner dropping req aborts job
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module delay_counter_arbiter
  import delay_counter_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

  state_t            state, state_n;
  logic [NREQ-1:0]   gnt_n, done_n;
  logic              busy_n;
  logic [WIDTH-1:0]  count_n, len_q, len_n;
  logic [IDXW-1:0]   last, last_n;

  logic [NREQ-1:0]   win_onehot;
  logic [IDXW-1:0]   win_idx;
  logic              any;
  logic [WIDTH-1:0]  lens [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign lens[g] = req_len[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_arbiter (
    .req        (req),
    .last       (last),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any        (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
      count <= '0;
      done  <= '0;
      len_q <= '0;
      last  <= LAST_RST;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
      count <= count_n;
      done  <= done_n;
      len_q <= len_n;
      last  <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    busy_n  = busy;
    count_n = count;
    done_n  = '0;
    len_n   = len_q;
    last_n  = last;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_n = ST_RUN;
          gnt_n   = win_onehot;
          busy_n  = 1'b1;
          count_n = '0;
          len_n   = lens[win_idx];
          last_n  = win_idx;
        end
      end
      ST_RUN: begin
`ifdef DELAY_COUNTER_ARBITER_ABORT_EN
        if ((req & gnt) == '0) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          count_n = '0;
        end else
`endif
        if (count == len_q) begin
          state_n = ST_DONE;
          done_n  = gnt;  // gnt is already one-hot on the owner
          gnt_n   = '0;
        end else begin
          count_n = count + WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        count_n = '0;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
        count_n = '0;
      end
    endcase
  end

endmodule

`default_nettype wire
